aging_scheduler: RTL

// Per-entry time-to-live scheduler for the associative buffer. Holds ENTRIES

---
 rtl/aging_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/aging_scheduler.sv
// ----------------------------------------------------------------------------
// aging_scheduler
//
// Per-entry time-to-live scheduler for the associative buffer. Each of ENTRIES
// slots counts down a time-to-live in seconds, driven by the shared one-second
// timer's second_elapsed pulse. The shared timer is enabled only while at least
// one slot is counting. Expired slots are arbitrated round-robin and offered
// one at a time to the buffer's eviction port over a valid/ready handshake.
//
// Ports
//   clk             system clock
//   async_nreset    asynchronous reset, active low
//   arm_valid       load arm_ttl into slot arm_idx this cycle
//   arm_idx         slot to arm
//   arm_ttl         seconds until expiry (0 expires immediately)
//   disarm_valid    cancel slot disarm_idx this cycle
//   disarm_idx      slot to cancel
//   second_elapsed  one-cycle tick from the shared timer
//   timer_enable    enable to the shared timer (any slot counting)
//   expire_valid    eviction request pending (registered)
//   expire_idx      slot to evict (registered, stable while expire_valid)
//   expire_ready    buffer accepts the eviction
//   active_mask     bit i set when slot i is counting or expired
// ----------------------------------------------------------------------------
module aging_scheduler #(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2,
    parameter int TTL_W   = 4
) (
    input  logic               clk,
    input  logic               async_nreset,
    input  logic               arm_valid,
    input  logic [IDX_W-1:0]   arm_idx,
    input  logic [TTL_W-1:0]   arm_ttl,
    input  logic               disarm_valid,
    input  logic [IDX_W-1:0]   disarm_idx,
    input  logic               second_elapsed,
    output logic               timer_enable,
    output logic               expire_valid,
    output logic [IDX_W-1:0]   expire_idx,
    input  logic               expire_ready,
    output logic [ENTRIES-1:0] active_mask
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COUNTING = 2'd1;
    localparam logic [1:0] ST_EXPIRED  = 2'd2;

    logic [1:0]       state_q [ENTRIES];
    logic [1:0]       state_d [ENTRIES];
    logic [TTL_W-1:0] count_q [ENTRIES];
    logic [TTL_W-1:0] count_d [ENTRIES];

    logic             expire_valid_q;
    logic [IDX_W-1:0] expire_idx_q;
    logic [IDX_W-1:0] rr_ptr_q;

    logic             handshake;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] grant_next;

    assign handshake = expire_valid_q && expire_ready;

    // ------------------------------------------------------------------
    // Per-slot next state. The presented slot is frozen until accepted;
    // otherwise arm beats disarm beats tick.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            // NOTE: every combinational output gets a default before any
            // conditional assignment so no path can infer a latch.
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            if (expire_valid_q && expire_idx_q == IDX_W'(i)) begin
                if (expire_ready) begin
                    state_d[i] = ST_IDLE;
                    count_d[i] = '0;
                end
            end else if (arm_valid && arm_idx == IDX_W'(i)) begin
                if (arm_ttl == '0) begin
                    state_d[i] = ST_EXPIRED;
                    count_d[i] = '0;
                end else begin
                    state_d[i] = ST_COUNTING;
                    count_d[i] = arm_ttl;
                end
            end else if (disarm_valid && disarm_idx == IDX_W'(i)) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (second_elapsed && state_q[i] == ST_COUNTING) begin
                if (count_q[i] == TTL_W'(1)) begin
                    state_d[i] = ST_EXPIRED;
                    count_d[i] = '0;
                end else begin
                    count_d[i] = count_q[i] - TTL_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search starting at rr_ptr. A candidate must be expired
    // now and still expired next cycle: this drops the slot being
    // acknowledged and any slot disarmed or re-armed to a nonzero TTL in
    // the same cycle, so a granted slot is always EXPIRED while presented.
    // ------------------------------------------------------------------
    always_comb begin
        int slot;
        grant_found = 1'b0;
        grant_idx   = '0;
        slot        = 0;
        for (int k = 0; k < ENTRIES; k++) begin
            slot = int'(rr_ptr_q) + k;
            if (slot >= ENTRIES) begin
                slot = slot - ENTRIES;
            end
            if (!grant_found && state_q[slot] == ST_EXPIRED &&
                state_d[slot] == ST_EXPIRED) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(slot);
            end
        end
    end

    assign grant_next = (grant_idx == IDX_W'(ENTRIES - 1)) ? '0
                                                           : grant_idx + IDX_W'(1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            // NOTE: the slot arrays are control state, not data storage, so
            // every element is reset; a pending eviction is dropped too.
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= ST_IDLE;
                count_q[i] <= '0;
            end
            expire_valid_q <= 1'b0;
            expire_idx_q   <= '0;
            rr_ptr_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values regardless of statement order.
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
            // The offer register only reloads when empty or just accepted,
            // so expire_idx stays put for the whole handshake.
            if (!expire_valid_q || handshake) begin
                expire_valid_q <= grant_found;
                if (grant_found) begin
                    expire_idx_q <= grant_idx;
                    rr_ptr_q     <= grant_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    always_comb begin
        timer_enable = 1'b0;
        active_mask  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_COUNTING) begin
                timer_enable = 1'b1;
            end
            active_mask[i] = (state_q[i] != ST_IDLE);
        end
    end

    assign expire_valid = expire_valid_q;
    assign expire_idx   = expire_idx_q;

endmodule
